// File: rtl/rotating_bank_buffer_if.sv
// Bus bundle for rotating_bank_buffer: write stream in, replayable read passes out.
// The master side (producer/consumer) drives data and commands; the slave is the buffer.
interface rotating_bank_buffer_if #(
  parameter int NUM_BANKS = 3,
  parameter int LANES     = 4,
  parameter int DATA_W    = 16
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int CNT_W  = $clog2(NUM_BANKS + 1);

  logic                          flush;

  logic                          wr_valid;
  logic                          wr_ready;
  logic [LANES-1:0][DATA_W-1:0]  wr_data;

  logic                          rd_start;
  logic                          rd_avail;
  logic                          rd_busy;
  logic                          rd_valid;
  logic [LANES-1:0][DATA_W-1:0]  rd_data;
  logic                          rd_last;
  logic                          rd_final_pass;
  logic [BANK_W-1:0]             rd_bank_idx;
  logic [CNT_W-1:0]              full_count;

  modport master (
    output flush, wr_valid, wr_data, rd_start,
    input  wr_ready, rd_avail, rd_busy, rd_valid, rd_data, rd_last,
           rd_final_pass, rd_bank_idx, full_count
  );

  modport slave (
    input  flush, wr_valid, wr_data, rd_start,
    output wr_ready, rd_avail, rd_busy, rd_valid, rd_data, rd_last,
           rd_final_pass, rd_bank_idx, full_count
  );
endinterface

// File: rtl/rotating_bank_buffer.sv
// Multi-bank ping-pong style buffer: a writer fills banks in rotation while a reader
// replays each full bank REPLAY times before handing it back to the writer.
module rotating_bank_buffer #(
  parameter int NUM_BANKS = 3,
  parameter int DEPTH     = 16,
  parameter int LANES     = 4,
  parameter int DATA_W    = 16,
  parameter int REPLAY    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rotating_bank_buffer_if.slave   bus
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(NUM_BANKS + 1);
  localparam int PASS_W = $clog2(REPLAY + 1);

  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(REPLAY - 1);

  typedef logic [LANES-1:0][DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  // READ issues one address per cycle; DONE is the rd_last cycle, after which
  // the bank is either re-armed for another pass or released.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_DONE
  } rd_state_t;

  bank_state_t bank_state_q [NUM_BANKS];
  bank_state_t bank_state_d [NUM_BANKS];

  rd_state_t           rd_state_q, rd_state_d;
  logic [BANK_W-1:0]   wr_bank_q,  wr_bank_d;
  logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
  logic [BANK_W-1:0]   rd_bank_q,  rd_bank_d;
  logic [ADDR_W-1:0]   rd_addr_q,  rd_addr_d;
  logic [PASS_W-1:0]   pass_q,     pass_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q,  rd_last_d;
  word_t               rd_data_q,  rd_data_d;

  word_t               mem_q [NUM_BANKS][DEPTH];
  logic                mem_we;

  logic                wr_ready;
  logic                wr_fire;
  logic                rd_avail;
  logic [CNT_W-1:0]    full_cnt;

  // ---------------------------------------------------------------------------
  // Status derived from registered state only
  // ---------------------------------------------------------------------------
  assign wr_ready = (bank_state_q[wr_bank_q] == BANK_EMPTY) ||
                    (bank_state_q[wr_bank_q] == BANK_FILLING);
  assign wr_fire  = bus.wr_valid && wr_ready;
  assign rd_avail = (rd_state_q == RD_IDLE) && (bank_state_q[rd_bank_q] == BANK_FULL);

  always_comb begin
    full_cnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_state_q[b] == BANK_FULL || bank_state_q[b] == BANK_DRAINING) begin
        full_cnt = full_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: write side, read FSM, then flush overrides both
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    bank_state_d = bank_state_q;
    rd_state_d   = rd_state_q;
    wr_bank_d    = wr_bank_q;
    wr_addr_d    = wr_addr_q;
    rd_bank_d    = rd_bank_q;
    rd_addr_d    = rd_addr_q;
    pass_d       = pass_q;
    mem_we       = 1'b0;

    rd_valid_d   = (rd_state_q == RD_READ);
    rd_last_d    = (rd_state_q == RD_READ) && (rd_addr_q == LAST_ADDR);
    rd_data_d    = (rd_state_q == RD_READ) ? mem_q[rd_bank_q][rd_addr_q] : rd_data_q;

    if (wr_fire) begin
      mem_we = 1'b1;
      if (wr_addr_q == LAST_ADDR) begin
        bank_state_d[wr_bank_q] = BANK_FULL;
        wr_addr_d               = '0;
        wr_bank_d               = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + BANK_W'(1);
      end else begin
        bank_state_d[wr_bank_q] = BANK_FILLING;
        wr_addr_d               = wr_addr_q + ADDR_W'(1);
      end
    end

    // The read bank is FULL/DRAINING and the write bank EMPTY/FILLING, so the
    // two updates below never touch the same entry.
    unique case (rd_state_q)
      RD_IDLE: begin
        if (bus.rd_start && rd_avail) begin
          rd_state_d              = RD_READ;
          rd_addr_d               = '0;
          bank_state_d[rd_bank_q] = BANK_DRAINING;
        end
      end
      RD_READ: begin
        if (rd_addr_q == LAST_ADDR) begin
          rd_addr_d  = '0;
          rd_state_d = RD_DONE;
        end else begin
          rd_addr_d  = rd_addr_q + ADDR_W'(1);
        end
      end
      RD_DONE: begin
        rd_state_d = RD_IDLE;
        if (pass_q == LAST_PASS) begin
          bank_state_d[rd_bank_q] = BANK_EMPTY;
          pass_d                  = '0;
          rd_bank_d               = (rd_bank_q == LAST_BANK) ? '0 : rd_bank_q + BANK_W'(1);
        end else begin
          bank_state_d[rd_bank_q] = BANK_FULL;
          pass_d                  = pass_q + PASS_W'(1);
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    // Flush wins over any concurrent write or pass start; rd_data keeps its value.
    if (bus.flush) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_state_d[b] = BANK_EMPTY;
      end
      rd_state_d = RD_IDLE;
      wr_bank_d  = '0;
      wr_addr_d  = '0;
      rd_bank_d  = '0;
      rd_addr_d  = '0;
      pass_d     = '0;
      mem_we     = 1'b0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      rd_data_d  = rd_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values
    // of its peers; blocking here would make results depend on statement order.
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_state_q[b] <= BANK_EMPTY;
      end
      rd_state_q <= RD_IDLE;
      wr_bank_q  <= '0;
      wr_addr_q  <= '0;
      rd_bank_q  <= '0;
      rd_addr_q  <= '0;
      pass_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      bank_state_q <= bank_state_d;
      rd_state_q   <= rd_state_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      rd_bank_q    <= rd_bank_d;
      rd_addr_q    <= rd_addr_d;
      pass_q       <= pass_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // NOTE: the storage array has no reset; bank state alone decides what is
  // valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_bank_q][wr_addr_q] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.wr_ready      = wr_ready;
  assign bus.rd_avail      = rd_avail;
  assign bus.rd_busy       = (rd_state_q != RD_IDLE);
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_last       = rd_last_q;
  assign bus.rd_final_pass = (rd_state_q != RD_IDLE) && (pass_q == LAST_PASS);
  assign bus.rd_bank_idx   = rd_bank_q;
  assign bus.full_count    = full_cnt;

endmodule

// File: doc/rotating_bank_buffer.md
ROTATING_BANK_BUFFER -- requirements
Module: rotating_bank_buffer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 3, number of rotating banks (>=2).
REQ-002 SHALL have parameter DEPTH, default 16, words per bank (>=2).
REQ-003 SHALL have parameter LANES, default 4, parallel data channels sharing one control path.
REQ-004 SHALL have parameter DATA_W, default 16, bits per lane word.
REQ-005 SHALL have parameter REPLAY, default 1, read passes per bank before release (>=1).
REQ-006 SHALL have ports: clk  in  1  single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: flush  in  1  synchronous clear; wr_valid  in  1; wr_ready  out  1; wr_data  in  LANES x DATA_W.
REQ-008 SHALL have ports: rd_start  in  1  begin one pass; rd_avail  out  1  head bank full, reader idle; rd_busy  out  1  pass in progress.
REQ-009 SHALL have ports: rd_valid  out  1; rd_data  out  LANES x DATA_W; rd_last  out  1  final word of pass; rd_final_pass  out  1  pass will release bank.
REQ-010 SHALL have ports: rd_bank_idx  out  clog2(NUM_BANKS)  bank being read; full_count  out  clog2(NUM_BANKS+1)  banks FULL or DRAINING.

Function
REQ-011 SHALL keep per-bank state EMPTY, FILLING, FULL, DRAINING; all banks start EMPTY.
REQ-012 SHALL hold write pointer wr_bank/wr_addr and read pointer rd_bank/rd_addr, both wrapping NUM_BANKS-1 -> 0 and DEPTH-1 -> 0.
REQ-013 SHALL drive wr_ready = 1 combinationally when bank[wr_bank] is EMPTY or FILLING, else 0.
REQ-014 SHALL on wr_valid & wr_ready store wr_data at (wr_bank, wr_addr) for all lanes, set bank FILLING, increment wr_addr.
REQ-015 SHALL on the write with wr_addr = DEPTH-1 set bank FULL, clear wr_addr, advance wr_bank next cycle.
REQ-016 SHALL ignore wr_data when wr_valid & !wr_ready (no state change, no overwrite).
REQ-017 SHALL drive rd_avail = 1 when bank[rd_bank] is FULL and read FSM is IDLE.
REQ-018 SHALL run read FSM IDLE -> READ on rd_start & rd_avail; rd_start while !rd_avail is ignored.
REQ-019 SHALL in READ issue addresses 0..DEPTH-1 one per cycle without stall, bank DRAINING during READ.
REQ-020 SHALL present rd_data with rd_valid exactly 1 cycle after address issue (registered read); rd_last with word DEPTH-1.
REQ-021 SHALL count passes; after pass n < REPLAY return to IDLE with bank FULL (rd_avail reasserts).
REQ-022 SHALL after pass REPLAY set bank EMPTY, reset pass count, advance rd_bank; rd_final_pass high for the whole final pass.
REQ-023 SHALL apply bank release at the cycle after rd_last; wr_ready for that bank may assert that cycle.
REQ-024 SHALL allow write into one bank and read of another in the same cycle with no interaction.
REQ-025 SHALL update full_count every cycle; fill-complete and release in same cycle leave it unchanged.
REQ-026 SHALL on flush return all banks EMPTY, pointers and pass count 0, FSM IDLE, abort any pass with rd_valid low next cycle; flush overrides concurrent writes/rd_start.
REQ-027 SHALL hold rd_data at last value when rd_valid = 0; contents are not cleared by flush or reset.

Reset
REQ-028 SHALL on rst_n low asynchronously set wr_ready 1, rd_avail 0, rd_busy 0, rd_valid 0, rd_last 0, rd_final_pass 0, rd_bank_idx 0, full_count 0, rd_data 0, all banks EMPTY, FSM IDLE.
REQ-029 SHALL when reset asserts mid-pass or mid-fill discard the partial bank and resume writes at bank 0 address 0 after release.

Verification (NUM_BANKS=3, DEPTH=4, LANES=2, DATA_W=16, REPLAY=2)
REQ-030 Write 4 words 0x0001..0x0004 -> bank0 FULL, full_count 1, rd_avail 1; rd_start -> rd_valid 4 cycles starting 1 cycle later, data 1..4, rd_last on 4th.
REQ-031 Fill 3 banks (12 words) no reads -> wr_ready 0, full_count 3; 13th wr_valid ignored and bank0 data unchanged on read.
REQ-032 REPLAY: two rd_start on bank0 -> identical 4-word streams, rd_final_pass only on 2nd; bank0 EMPTY and rd_bank_idx 1 after.
REQ-033 Concurrent: bank1 filling while bank0 draining -> both streams correct; wrap: 4 banks' worth through 3 banks returns data in order.
REQ-034 flush during word 2 of a pass -> rd_valid 0 next cycle, full_count 0, wr_ready 1, next write lands in bank0 addr0.
REQ-035 rst_n low mid-fill of bank1 (2 words) -> all outputs at REQ-028 values immediately; after release 4 writes produce bank0 FULL.
